fft_frame_serializer: RTL and testbench
=======================================

FFT_FRAME_SERIALIZER -- requirements
Module: fft_frame_serializer

Interface
REQ-001 SHALL have parameter LGSIZE, default 5: log2 FFT size N; frame = N bins = N/2 input pairs.
REQ-002 SHALL have parameter WIDTH, default 24: bits per real/imag component; complex sample = 2*WIDTH.
REQ-003 SHALL have parameter LGFIFO, default 4: log2 FIFO depth in input pairs.
REQ-004 SHALL have port i_clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port i_reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_clk_enable  in  1  input pair valid this cycle.
REQ-007 SHALL have port i_in_0  in  2*WIDTH  bin 2p of pair p.
REQ-008 SHALL have port i_in_1  in  2*WIDTH  bin 2p+1 of pair p.
REQ-009 SHALL have port i_sync  in  1  qualified by i_clk_enable; marks pair 0 of a frame.
REQ-010 SHALL have port o_valid  out  1  output beat valid.
REQ-011 SHALL have port i_ready  in  1  downstream accepts beat.
REQ-012 SHALL have port o_data  out  2*WIDTH  one complex bin per beat.
REQ-013 SHALL have port o_bin  out  LGSIZE  bin index of o_data.
REQ-014 SHALL have port o_first  out  1  high with bin 0.
REQ-015 SHALL have port o_last  out  1  high with bin N-1.
REQ-016 SHALL have port o_fill  out  LGFIFO+1  pairs held in FIFO.
REQ-017 SHALL have port o_overflow  out  1  sticky: pair dropped because FIFO full.
REQ-018 SHALL have port i_clear_ovf  in  1  clears o_overflow.

Function
REQ-019 Write FSM SHALL have states HUNT and RUN; reset state HUNT.
REQ-020 HUNT: pairs with i_clk_enable && !i_sync SHALL be discarded; i_clk_enable && i_sync SHALL push the pair (tagged first) and go to RUN.
REQ-021 RUN: every i_clk_enable pair SHALL be pushed, entry tag = i_sync; a sync mid-frame SHALL be tagged first and accepted as a new frame start.
REQ-022 Push with FIFO full (and no same-cycle pop freeing a slot) SHALL drop the pair, set o_overflow, and move FSM to HUNT.
REQ-023 FIFO entry SHALL be {first tag, i_in_1, i_in_0}; depth 2^LGFIFO pairs; pointers wrap modulo depth; simultaneous push and pop at full or empty SHALL be legal and keep o_fill consistent.
REQ-024 Output SHALL serialize each pair as i_in_0 beat then i_in_1 beat.
REQ-025 A beat transfers when o_valid && i_ready; while o_valid && !i_ready, o_data, o_bin, o_first, o_last SHALL hold stable and o_valid SHALL stay high.
REQ-026 o_bin SHALL be 0 on the first beat of a tagged pair, else previous transferred o_bin + 1 modulo N.
REQ-027 o_first SHALL equal (o_bin == 0); o_last SHALL equal (o_bin == N-1); a truncated frame yields no o_last.
REQ-028 With FIFO empty, output idle, i_ready=1: a pair pushed at edge E SHALL present its first beat valid after edge E+2, its second after edge E+3.
REQ-029 Sustained throughput SHALL be one beat per clock; i_clk_enable duty above 50% with i_ready=1 eventually overflows, which is legal.
REQ-030 o_overflow: set wins over simultaneous i_clear_ovf; cleared only by i_clear_ovf or reset.

Reset
REQ-031 i_reset_n low SHALL immediately clear FIFO pointers, FSM to HUNT, and drive o_valid, o_data, o_bin, o_first, o_last, o_fill, o_overflow to 0, regardless of clock.
REQ-032 Reset mid-frame SHALL discard all buffered data; after release no beat appears until a new i_sync pair.

Verification (N=32, LGFIFO=4)
REQ-033 Assert i_reset_n=0 mid-frame between edges -> all outputs 0 before next edge; after release, 3 non-sync pairs produce no o_valid.
REQ-034 Sync frame, i_clk_enable every other cycle, i_ready=1 -> 32 beats, o_bin 0..31, o_first on 0, o_last on 31, order in0,in1 per pair, o_overflow=0.
REQ-035 i_ready=0, 17 consecutive pairs (sync on 1st and 17th) -> o_fill=16, o_overflow=1, 17th dropped; release i_ready -> 32 beats with o_last at bin 31, later non-sync pairs dropped until next sync.
REQ-036 Random i_ready toggling during a frame -> o_data/o_bin stable while stalled, no beat lost or duplicated.
REQ-037 Sync re-asserted at pair 5 of a frame -> o_bin returns to 0 at that pair, o_last never seen for truncated frame.
REQ-038 o_overflow set and i_clear_ovf asserted same cycle as a new drop -> o_overflow stays 1; clear alone next cycle -> 0.

Source files
------------

// File: rtl/fft_frame_serializer.sv
// Buffers FFT output pairs in a small FIFO and replays them as one complex bin per beat,
// with ready/valid flow control, bin numbering and a sticky overflow flag.
module fft_frame_serializer #(
  parameter int LGSIZE = 5,
  parameter int WIDTH  = 24,
  parameter int LGFIFO = 4
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_clk_enable,
  input  logic [2*WIDTH-1:0]  i_in_0,
  input  logic [2*WIDTH-1:0]  i_in_1,
  input  logic                i_sync,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [2*WIDTH-1:0]  o_data,
  output logic [LGSIZE-1:0]   o_bin,
  output logic                o_first,
  output logic                o_last,
  output logic [LGFIFO:0]     o_fill,
  output logic                o_overflow,
  input  logic                i_clear_ovf
);

  localparam int DW    = 2 * WIDTH;
  localparam int DEPTH = 1 << LGFIFO;
  localparam logic [LGFIFO:0] CNT_ONE  = (LGFIFO+1)'(1);
  localparam logic [LGFIFO:0] CNT_FULL = (LGFIFO+1)'(DEPTH);

  typedef struct packed {
    logic          first;
    logic [DW-1:0] d1;
    logic [DW-1:0] d0;
  } entry_t;

  typedef enum logic {HUNT, RUN} wstate_t;

  entry_t            mem [DEPTH];
  logic [LGFIFO-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [LGFIFO:0]   fill;
  wstate_t           state, state_nx;
  logic              push_req, push, pop, drop, full;

  // Pair register: a copy of the FIFO head being serialized; the head is
  // only popped once its second beat moves into the output register.
  entry_t            pair_q;
  logic              pv, phase, adv;
  logic [LGSIZE-1:0] beat_bin;

  assign full     = (fill == CNT_FULL);
  assign rd_nxt   = rd_ptr + 1'b1;
  assign adv      = pv && (!o_valid || i_ready);
  assign pop      = adv && phase;
  assign push_req = i_clk_enable && (state == RUN || i_sync);
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && !push;
  assign beat_bin = (!phase && pair_q.first) ? '0 : o_bin + LGSIZE'(1);
  assign o_fill   = fill;

  always_comb begin
    state_nx = state;
    if (drop)      state_nx = HUNT;
    else if (push) state_nx = RUN;
  end

  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) state <= HUNT;
    else            state <= state_nx;

  always_ff @(posedge i_clk)
    if (push) mem[wr_ptr] <= '{first: i_sync, d1: i_in_1, d0: i_in_0};

  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_nxt;
      case ({push, pop})
        2'b10:   fill <= fill + CNT_ONE;
        2'b01:   fill <= fill - CNT_ONE;
        default: fill <= fill;
      endcase
      if (drop)             o_overflow <= 1'b1;
      else if (i_clear_ovf) o_overflow <= 1'b0;
    end

  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      pv     <= 1'b0;
      phase  <= 1'b0;
      pair_q <= '0;
    end else if (!pv) begin
      if (fill != '0) begin
        pv     <= 1'b1;
        phase  <= 1'b0;
        pair_q <= mem[rd_ptr];
      end
    end else if (adv) begin
      if (!phase) begin
        phase <= 1'b1;
      end else if (fill > CNT_ONE) begin
        // Next entry is already resident: reload without a bubble.
        phase  <= 1'b0;
        pair_q <= mem[rd_nxt];
      end else begin
        pv <= 1'b0;
      end
    end

  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_bin   <= '0;
      o_first <= 1'b0;
      o_last  <= 1'b0;
    end else if (adv) begin
      o_valid <= 1'b1;
      o_data  <= phase ? pair_q.d1 : pair_q.d0;
      o_bin   <= beat_bin;
      o_first <= (beat_bin == '0);
      o_last  <= (beat_bin == {LGSIZE{1'b1}});
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Directed bench for fft_frame_serializer (N=32, 16-pair FIFO) with a beat scoreboard.
module tb_fft_frame_serializer;

  logic        i_clk, i_reset_n, i_clk_enable, i_sync, i_ready, i_clear_ovf;
  logic [47:0] i_in_0, i_in_1, o_data;
  logic        o_valid, o_first, o_last, o_overflow;
  logic [4:0]  o_bin;
  logic [4:0]  o_fill;

  fft_frame_serializer #(.LGSIZE(5), .WIDTH(24), .LGFIFO(4)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_clk_enable(i_clk_enable),
    .i_in_0(i_in_0), .i_in_1(i_in_1), .i_sync(i_sync),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_bin(o_bin),
    .o_first(o_first), .o_last(o_last), .o_fill(o_fill),
    .o_overflow(o_overflow), .i_clear_ovf(i_clear_ovf)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0, bad = 0;
  int nbeats = 0, nlast = 0, nstall = 0;
  logic mon_on = 1'b0, rnd_rdy = 1'b0;

  typedef struct {logic [47:0] d; logic [4:0] b;} beat_t;
  beat_t q[$];
  logic [4:0] eb = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] dat(input int f, input int p, input int k);
    return {16'(f), 16'(p), (k != 0) ? 16'hBEEF : 16'h1234};
  endfunction

  task automatic add_pair(input int f, input int p, input logic first);
    if (first) eb = '0;
    q.push_back('{dat(f, p, 0), eb});
    q.push_back('{dat(f, p, 1), eb + 5'd1});
    eb = eb + 5'd2;
  endtask

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input int f, input int p, input logic s);
    i_clk_enable = 1'b1;
    i_in_0 = dat(f, p, 0);
    i_in_1 = dat(f, p, 1);
    i_sync = s;
    step();
    i_clk_enable = 1'b0;
    i_sync = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 300 && q.size() != 0; i++) step();
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  // Scoreboard and stall-stability monitor; samples midway between active edges.
  logic        prev_stall = 1'b0;
  logic [47:0] pd;
  logic [4:0]  pb;
  always @(negedge i_clk) begin
    if (mon_on && i_reset_n) begin
      if (prev_stall) begin
        chk("hold_valid", 64'(o_valid), 64'd1);
        chk("hold_data", 64'(o_data), 64'(pd));
        chk("hold_bin", 64'(o_bin), 64'(pb));
      end
      if (o_valid && i_ready) begin
        nbeats++;
        if (o_last) nlast++;
        if (q.size() == 0) chk("extra_beat", 64'd1, 64'd0);
        else begin
          beat_t e;
          e = q.pop_front();
          chk("beat_data", 64'(o_data), 64'(e.d));
          chk("beat_bin", 64'(o_bin), 64'(e.b));
          chk("beat_first", 64'(o_first), 64'(e.b == 5'd0));
          chk("beat_last", 64'(o_last), 64'(e.b == 5'd31));
        end
      end
      if (o_valid && !i_ready) nstall++;
      prev_stall = o_valid && !i_ready;
      pd = o_data;
      pb = o_bin;
    end else prev_stall = 1'b0;
  end

  always @(posedge i_clk)
    if (rnd_rdy) begin
      #1 i_ready = ($urandom_range(0, 3) != 0);
    end

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  int b0, l0, s0;
  initial begin
    i_reset_n = 1'b1; i_clk_enable = 1'b0; i_sync = 1'b0; i_ready = 1'b0;
    i_clear_ovf = 1'b0; i_in_0 = '0; i_in_1 = '0;
    #1 i_reset_n = 1'b0;
    #1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_fill", 64'(o_fill), 64'd0);
    chk("rst_ovf", 64'(o_overflow), 64'd0);
    step(); step();
    i_reset_n = 1'b1;

    // Partial frame stalled downstream, then asynchronous reset between edges.
    send(0, 0, 1'b1); send(0, 1, 1'b0); send(0, 2, 1'b0); send(0, 3, 1'b0);
    chk("pre_fill", 64'(o_fill), 64'd4);
    chk("pre_valid", 64'(o_valid), 64'd1);
    #3 i_reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(o_valid), 64'd0);
    chk("mid_rst_data", 64'(o_data), 64'd0);
    chk("mid_rst_bin", 64'(o_bin), 64'd0);
    chk("mid_rst_first", 64'(o_first), 64'd0);
    chk("mid_rst_last", 64'(o_last), 64'd0);
    chk("mid_rst_fill", 64'(o_fill), 64'd0);
    @(posedge i_clk); #1 i_reset_n = 1'b1;
    i_ready = 1'b1;
    mon_on = 1'b1;
    send(0, 4, 1'b0); send(0, 5, 1'b0); send(0, 6, 1'b0);
    repeat (6) step();
    chk("post_rst_beats", 64'(nbeats), 64'd0);

    // First-beat latency from an idle pipeline.
    add_pair(1, 0, 1'b1);
    send(1, 0, 1'b1);
    chk("lat_e0", 64'(o_valid), 64'd0);
    step(); chk("lat_e1", 64'(o_valid), 64'd0);
    step(); chk("lat_e2_valid", 64'(o_valid), 64'd1);
    chk("lat_e2_data", 64'(o_data), 64'(dat(1, 0, 0)));
    step(); chk("lat_e3_data", 64'(o_data), 64'(dat(1, 0, 1)));
    drain();

    // Full frame at 50% input duty.
    b0 = nbeats; l0 = nlast;
    for (int p = 0; p < 16; p++) begin
      add_pair(2, p, p == 0);
      send(2, p, p == 0);
      step();
    end
    drain();
    chk("frame_beats", 64'(nbeats - b0), 64'd32);
    chk("frame_last", 64'(nlast - l0), 64'd1);
    chk("frame_ovf", 64'(o_overflow), 64'd0);

    // Overflow with downstream stalled; 17th pair (a sync) is dropped.
    i_ready = 1'b0;
    for (int p = 0; p < 17; p++) begin
      if (p < 16) add_pair(6, p, p == 0);
      send(6, p, (p == 0) || (p == 16));
    end
    chk("ovf_fill", 64'(o_fill), 64'd16);
    chk("ovf_set", 64'(o_overflow), 64'd1);
    i_clear_ovf = 1'b1;
    send(7, 0, 1'b1);
    chk("ovf_set_wins", 64'(o_overflow), 64'd1);
    chk("ovf_fill_hold", 64'(o_fill), 64'd16);
    step();
    chk("ovf_cleared", 64'(o_overflow), 64'd0);
    i_clear_ovf = 1'b0;
    b0 = nbeats; l0 = nlast;
    i_ready = 1'b1;
    drain();
    chk("ovf_beats", 64'(nbeats - b0), 64'd32);
    chk("ovf_last", 64'(nlast - l0), 64'd1);
    b0 = nbeats;
    send(8, 0, 1'b0); send(8, 1, 1'b0);
    repeat (6) step();
    chk("hunt_drop", 64'(nbeats - b0), 64'd0);
    chk("hunt_fill", 64'(o_fill), 64'd0);

    // Random downstream backpressure during a frame.
    b0 = nbeats; s0 = nstall;
    rnd_rdy = 1'b1;
    for (int p = 0; p < 16; p++) begin
      add_pair(9, p, p == 0);
      send(9, p, p == 0);
      step(); step();
    end
    rnd_rdy = 1'b0;
    step();
    i_ready = 1'b1;
    drain();
    chk("rnd_beats", 64'(nbeats - b0), 64'd32);
    chk("rnd_stalled", 64'(nstall > s0), 64'd1);
    chk("rnd_ovf", 64'(o_overflow), 64'd0);

    // Sync re-asserted at pair 5: truncated frame then a full one.
    b0 = nbeats; l0 = nlast;
    for (int p = 0; p < 21; p++) begin
      if (p < 5) begin add_pair(10, p, p == 0); send(10, p, p == 0); end
      else begin add_pair(11, p - 5, p == 5); send(11, p - 5, p == 5); end
      step();
    end
    drain();
    chk("trunc_beats", 64'(nbeats - b0), 64'd42);
    chk("trunc_last", 64'(nlast - l0), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
